// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Build option: HAZARD_PERF_EN adds stall/flush performance counters.
package hazard_pkg;

    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} hz_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [31:0] REG_X0    = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
// Build option: HAZARD_PERF_EN adds Stall_Count/Flush_Count.
interface hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_W     = 32
);
    logic [REG_ADDR_W-1:0] Rs1_D;
    logic [REG_ADDR_W-1:0] Rs2_D;
    logic [REG_ADDR_W-1:0] Rd_E;
    logic                  Mem_Read_E;
    logic                  Branch_Taken_E;
    logic                  Mem_Wait;
    logic                  Stall_F;
    logic                  Stall_En;
    logic                  Stall_E;
    logic                  Flush_D;
    logic                  Flush_E;
    logic                  Wait_Timeout;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0]     Stall_Count;
    logic [PERF_W-1:0]     Flush_Count;
`endif

    // Datapath side
    modport master (
        output Rs1_D, Rs2_D, Rd_E, Mem_Read_E, Branch_Taken_E, Mem_Wait,
        input  Stall_F, Stall_En, Stall_E, Flush_D, Flush_E, Wait_Timeout
`ifdef HAZARD_PERF_EN
        , input Stall_Count, Flush_Count
`endif
    );

    // Hazard controller side
    modport slave (
        input  Rs1_D, Rs2_D, Rd_E, Mem_Read_E, Branch_Taken_E, Mem_Wait,
        output Stall_F, Stall_En, Stall_E, Flush_D, Flush_E, Wait_Timeout
`ifdef HAZARD_PERF_EN
        , output Stall_Count, Flush_Count
`endif
    );

endinterface

// File: rtl/hazard_wait_timer.sv
// Saturating memory-wait cycle counter with a sticky timeout flag.
module hazard_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    input  logic run,
    output logic Wait_Timeout
);
    localparam logic [7:0] MaxCount = 8'(WAIT_MAX);

    logic [7:0] count_q, count_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        count_d = '0;
        if (start) begin
            count_d = 8'd1;
        end else if (run) begin
            count_d = (count_q >= MaxCount) ? count_q : count_q + 8'd1;
        end
        timeout_d = timeout_q | (count_d == MaxCount);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign Wait_Timeout = timeout_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash, memory-wait freeze.
// Build option: HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned WAIT_MAX   = 15,
    parameter int unsigned PERF_W     = 32
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  bus
);
    hz_state_t state_q, state_d;
    logic      load_use, lu_eff;
    logic      stall_f, stall_en, stall_e, flush_d, flush_e;

    assign load_use = bus.Mem_Read_E && (bus.Rd_E != REG_X0[REG_ADDR_W-1:0]) &&
                      ((bus.Rd_E == bus.Rs1_D) || (bus.Rd_E == bus.Rs2_D));
    // The bubble already inserted covers the load, so detection is masked for one cycle.
    assign lu_eff   = load_use && (state_q != LOAD_STALL);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = RUN;
        if (bus.Mem_Wait)            state_d = MEM_WAIT;
        else if (bus.Branch_Taken_E) state_d = RUN;
        else if (lu_eff)             state_d = LOAD_STALL;
    end

    // A freeze always wins; leaving MEM_WAIT falls through to the RUN rules.
    always_comb begin
        stall_f  = 1'b0;
        stall_en = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        if (bus.Mem_Wait) begin
            stall_f  = 1'b1;
            stall_en = 1'b1;
            stall_e  = 1'b1;
        end else if (bus.Branch_Taken_E) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
        end else if (lu_eff) begin
            stall_f  = 1'b1;
            stall_en = 1'b1;
            flush_e  = 1'b1;
        end
    end

    assign bus.Stall_F  = stall_f  & ~RST;
    assign bus.Stall_En = stall_en & ~RST;
    assign bus.Stall_E  = stall_e  & ~RST;
    assign bus.Flush_D  = flush_d  & ~RST;
    assign bus.Flush_E  = flush_e  & ~RST;

    hazard_wait_timer #(
        .WAIT_MAX     (WAIT_MAX)
    ) u_wait_timer (
        .CLK          (CLK),
        .RST          (RST),
        .start        (bus.Mem_Wait && (state_q != MEM_WAIT)),
        .run          (bus.Mem_Wait && (state_q == MEM_WAIT)),
        .Wait_Timeout (bus.Wait_Timeout)
    );

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.Stall_En && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if ((bus.Flush_D || bus.Flush_E) && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.Stall_Count = stall_cnt_q;
    assign bus.Flush_Count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios then random traffic
// against a behavioural model (WAIT_MAX=4 so timeouts are reachable).
module tb_hazard_ctrl;
    localparam int unsigned AW      = 5;
    localparam int unsigned WaitMax = 4;

    logic        CLK = 1'b0;
    logic        RST;
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    hazard_ctrl_if #(.REG_ADDR_W(AW), .PERF_W(32)) h ();

    hazard_ctrl #(
        .REG_ADDR_W (AW),
        .WAIT_MAX   (WaitMax),
        .PERF_W     (32)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (h)
    );

    always #5 CLK = ~CLK;

    // Model: "previous cycle issued a load-use bubble", consecutive Mem_Wait cycles,
    // sticky timeout, and event tallies.
    bit          m_ls;
    int unsigned m_run;
    bit          m_to;
    int unsigned m_sc, m_fc;

    // {Stall_F, Stall_En, Stall_E, Flush_D, Flush_E}
    function automatic logic [4:0] model_ctl();
        bit lu;
        lu = h.Mem_Read_E && (h.Rd_E != 0) && ((h.Rd_E == h.Rs1_D) || (h.Rd_E == h.Rs2_D));
        if (h.Mem_Wait)       return 5'b11100;
        if (h.Branch_Taken_E) return 5'b00011;
        if (lu && !m_ls)      return 5'b11001;
        return 5'b00000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl_obs();
        return {27'b0, h.Stall_F, h.Stall_En, h.Stall_E, h.Flush_D, h.Flush_E};
    endfunction

    task automatic model_clear();
        m_ls = 0; m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input string tag, input bit mr, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input bit br, input bit mw);
        logic [4:0] e;
        h.Mem_Read_E = mr; h.Rd_E = rd; h.Rs1_D = rs1; h.Rs2_D = rs2;
        h.Branch_Taken_E = br; h.Mem_Wait = mw;
        @(negedge CLK);
        e = model_ctl();
        chk({tag, "/ctl"}, ctl_obs(), {27'b0, e});
        chk({tag, "/timeout"}, {31'b0, h.Wait_Timeout}, {31'b0, m_to});
        @(posedge CLK);
        m_sc  += e[3];
        m_fc  += (e[1] | e[0]);
        m_ls   = (e == 5'b11001);
        m_run  = mw ? ((m_run + 1 > WaitMax) ? WaitMax : m_run + 1) : 0;
        if (m_run >= WaitMax) m_to = 1;
        #1;
`ifdef HAZARD_PERF_EN
        chk({tag, "/stall_count"}, h.Stall_Count, m_sc);
        chk({tag, "/flush_count"}, h.Flush_Count, m_fc);
`endif
    endtask

    // Asynchronous reset between edges with current inputs still applied.
    task automatic reset_mid(input string tag);
        #2 RST = 1'b1;
        #1;
        chk({tag, "/ctl"}, ctl_obs(), 32'h0);
        chk({tag, "/timeout"}, {31'b0, h.Wait_Timeout}, 32'h0);
`ifdef HAZARD_PERF_EN
        chk({tag, "/stall_count"}, h.Stall_Count, 32'h0);
        chk({tag, "/flush_count"}, h.Flush_Count, 32'h0);
`endif
        @(posedge CLK);
        #1 RST = 1'b0;
        model_clear();
    endtask

    initial begin
        bit          mw_prev;
        bit          mw;
        RST = 1'b1;
        h.Mem_Read_E = 0; h.Rd_E = 0; h.Rs1_D = 0; h.Rs2_D = 0;
        h.Branch_Taken_E = 0; h.Mem_Wait = 0;
        model_clear();
        @(posedge CLK);
        #1;
        chk("reset/ctl", ctl_obs(), 32'h0);
        chk("reset/timeout", {31'b0, h.Wait_Timeout}, 32'h0);
        RST = 1'b0;

        // Load-use: one bubble then released even though the operands still match
        cycle("lu",       1, 5, 0, 5, 0, 0);
        cycle("lu_hold",  1, 5, 0, 5, 0, 0);
        cycle("idle",     0, 0, 0, 0, 0, 0);
        cycle("lu_rs1",   1, 7, 7, 3, 0, 0);
        cycle("idle",     0, 0, 0, 0, 0, 0);
        cycle("lu_x0",    1, 0, 0, 0, 0, 0);
        cycle("no_load",  0, 5, 5, 5, 0, 0);
        // Branch squashes the pending load-use
        cycle("br_lu",    1, 5, 5, 0, 1, 0);
        cycle("idle",     0, 0, 0, 0, 0, 0);

        // Short memory wait, no timeout
        for (int i = 0; i < 3; i++) cycle("mw3", 0, 0, 0, 0, 0, 1);
        cycle("mw3_exit", 0, 0, 0, 0, 0, 0);
        chk("mw3/timeout", {31'b0, h.Wait_Timeout}, 32'h0);

        // Long memory wait: timeout visible after the WAIT_MAX-th freeze cycle
        for (int i = 1; i <= 6; i++) begin
            cycle("mw6", 0, 0, 0, 0, 0, 1);
            if (i == 3) chk("mw6/timeout_before", {31'b0, h.Wait_Timeout}, 32'h0);
            if (i == 4) chk("mw6/timeout_at_max", {31'b0, h.Wait_Timeout}, 32'h1);
        end
        cycle("mw6_exit", 0, 0, 0, 0, 0, 0);
        cycle("mw6_after", 0, 0, 0, 0, 0, 0);
        chk("mw6/timeout_held", {31'b0, h.Wait_Timeout}, 32'h1);

        // Branch held in frozen Execute acts on the first cycle after exit
        cycle("br_frozen", 0, 0, 0, 0, 1, 1);
        cycle("br_frozen", 0, 0, 0, 0, 1, 1);
        cycle("br_exit",   0, 0, 0, 0, 1, 0);
        // Load-use during wait exit follows RUN rules
        cycle("lu_frozen", 1, 9, 9, 0, 0, 1);
        cycle("lu_exit",   1, 9, 9, 0, 0, 0);
        cycle("lu_masked", 1, 9, 9, 0, 0, 0);
        cycle("ls_mw",     1, 9, 9, 0, 0, 1);
        cycle("ls_mw_out", 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a freeze with timeout already set
        cycle("pre_rst", 0, 0, 0, 0, 0, 1);
        cycle("pre_rst", 0, 0, 0, 0, 0, 1);
        reset_mid("rst_mid");
        cycle("post_rst", 0, 0, 0, 0, 0, 0);

        // Counter scenario: two load-use events and one branch
        reset_mid("rst_perf");
        cycle("perf_lu1", 1, 5, 0, 5, 0, 0);
        cycle("perf_idle", 0, 0, 0, 0, 0, 0);
        cycle("perf_lu2", 1, 6, 6, 0, 0, 0);
        cycle("perf_idle", 0, 0, 0, 0, 0, 0);
        cycle("perf_br", 0, 0, 0, 0, 1, 0);
`ifdef HAZARD_PERF_EN
        chk("perf/stall_count_2", h.Stall_Count, 32'd2);
        chk("perf/flush_count_3", h.Flush_Count, 32'd3);
`endif

        // Random traffic; Mem_Wait is bursty so timeouts occur
        mw_prev = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_mid("rnd_rst");
                mw_prev = 0;
            end
            mw = mw_prev ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
            cycle("rnd", 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0), mw);
            mw_prev = mw;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
